// File: rtl/disp_pkg.sv
// Shared types and constants for the digit display scheduler.
// Holds the state encoding, display word width and default divider settings.
package disp_pkg;

    localparam int DISP_W         = 16;
    localparam int SCAN_DIV_DEF   = 50000;
    localparam int FRESH_DIV_DEF  = 100;
    localparam int HOLD_FRESH_DEF = 8;

    typedef enum logic {
        SHOW_MEAS = 1'b0,
        SHOW_SET  = 1'b1
    } disp_state_e;

    // A counter for a modulus of 1 still needs one bit of storage.
    function automatic int cnt_w(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-DIV event counter; tick is high while en is high and the count is DIV-1.
// The strobe is combinational so cascaded dividers stay aligned to the same cycle.
module tick_divider
    import disp_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW   = cnt_w(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/digit_disp_sched.sv
// Display scheduler: scan/refresh strobes plus arbitration between the latest
// measurement and a user setting that temporarily takes over the display.
module digit_disp_sched
    import disp_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_DEF,
    parameter int FRESH_DIV  = FRESH_DIV_DEF,
    parameter int HOLD_FRESH = HOLD_FRESH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              meas_valid,
    input  logic [DISP_W-1:0] meas_data,
    output logic              meas_ready,
    input  logic              set_valid,
    input  logic [DISP_W-1:0] set_data,
    output logic              set_ready,
    output logic [DISP_W-1:0] disp_data,
    output logic              src_sel,
    output logic              scan_tick,
    output logic              fresh_tick
);

    localparam int            HW        = cnt_w(HOLD_FRESH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRESH - 1);

    logic scan_pre, fresh_pre;

    // The refresh divider counts the scan strobe ahead of its output register,
    // so the registered scan_tick and fresh_tick pulse in the same cycle.
    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk (clk), .rst (rst), .en (1'b1), .tick (scan_pre)
    );
    tick_divider #(.DIV(FRESH_DIV)) u_fresh_div (
        .clk (clk), .rst (rst), .en (scan_pre), .tick (fresh_pre)
    );

    logic              scan_tick_q, scan_tick_d, fresh_tick_q, fresh_tick_d;
    logic              alive_q, alive_d;
    logic              meas_full_q, meas_full_d, set_full_q, set_full_d;
    logic [DISP_W-1:0] meas_buf_q, meas_buf_d, set_buf_q, set_buf_d;
    logic [DISP_W-1:0] last_meas_q, last_meas_d, disp_q, disp_d, lm;
    logic [HW-1:0]     hold_q, hold_d;
    disp_state_e       state_q, state_d;
    logic              meas_take, set_take;

    // alive_q keeps both ready outputs low for the first cycle out of reset.
    assign meas_ready = alive_q & ~meas_full_q;
    assign set_ready  = alive_q & ~set_full_q;
    assign meas_take  = meas_valid & meas_ready;
    assign set_take   = set_valid & set_ready;
    assign disp_data  = disp_q;
    assign src_sel    = (state_q == SHOW_SET);
    assign scan_tick  = scan_tick_q;
    assign fresh_tick = fresh_tick_q;

    always_comb begin
        scan_tick_d  = scan_pre;
        fresh_tick_d = fresh_pre;
        alive_d      = 1'b1;
        meas_full_d  = meas_full_q;
        meas_buf_d   = meas_buf_q;
        set_full_d   = set_full_q;
        set_buf_d    = set_buf_q;
        last_meas_d  = last_meas_q;
        disp_d       = disp_q;
        hold_d       = hold_q;
        state_d      = state_q;
        lm           = last_meas_q;

        if (fresh_tick_q) begin
            case (state_q)
                SHOW_MEAS: begin
                    if (set_full_q) begin
                        state_d    = SHOW_SET;
                        disp_d     = set_buf_q;
                        set_full_d = 1'b0;
                        hold_d     = HOLD_LAST;
                    end else if (meas_full_q) begin
                        disp_d      = meas_buf_q;
                        last_meas_d = meas_buf_q;
                        meas_full_d = 1'b0;
                    end
                end
                SHOW_SET: begin
                    // Measurements keep draining into the shadow while a setting is shown.
                    if (meas_full_q) begin
                        lm          = meas_buf_q;
                        last_meas_d = meas_buf_q;
                        meas_full_d = 1'b0;
                    end
                    if (set_full_q) begin
                        disp_d     = set_buf_q;
                        set_full_d = 1'b0;
                        hold_d     = HOLD_LAST;
                    end else if (hold_q == '0) begin
                        state_d = SHOW_MEAS;
                        disp_d  = lm;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (meas_take) begin
            meas_full_d = 1'b1;
            meas_buf_d  = meas_data;
        end
        if (set_take) begin
            set_full_d = 1'b1;
            set_buf_d  = set_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_tick_q  <= 1'b0;
            fresh_tick_q <= 1'b0;
            alive_q      <= 1'b0;
            meas_full_q  <= 1'b0;
            meas_buf_q   <= '0;
            set_full_q   <= 1'b0;
            set_buf_q    <= '0;
            last_meas_q  <= '0;
            disp_q       <= '0;
            hold_q       <= '0;
            state_q      <= SHOW_MEAS;
        end else begin
            scan_tick_q  <= scan_tick_d;
            fresh_tick_q <= fresh_tick_d;
            alive_q      <= alive_d;
            meas_full_q  <= meas_full_d;
            meas_buf_q   <= meas_buf_d;
            set_full_q   <= set_full_d;
            set_buf_q    <= set_buf_d;
            last_meas_q  <= last_meas_d;
            disp_q       <= disp_d;
            hold_q       <= hold_d;
            state_q      <= state_d;
        end
    end

endmodule
